// File: rtl/dmem_responder.sv
// dmem_responder
//
// Data-memory target for the multicycle MIPS CPU data port. It serves word
// loads (combinational) and stores into a small word array, and decodes a
// memory-mapped tohost word whose write ends a benchtest with done/pass.
// Every accepted store is also recorded in a first-word-fall-through log.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low (0 = in reset)
//   memwrite     store strobe, one store per high cycle
//   dataaddr     byte address for loads and stores
//   writedata    store data
//   readdata     combinational load data
//   log_pop      consume the log head
//   log_valid    log is non-empty
//   log_addr     head entry address
//   log_data     head entry data
//   log_count    number of log entries held
//   log_overflow sticky, a push was dropped because the log was full
//   misaligned   sticky, a store arrived with dataaddr[1:0] != 0
//   done         sticky, tohost has been written
//   pass         tohost value captured with done was 1
module dmem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          LOG_DEPTH   = 8,
  parameter logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         memwrite,
  input  logic [31:0]                  dataaddr,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  input  logic                         log_pop,
  output logic                         log_valid,
  output logic [31:0]                  log_addr,
  output logic [31:0]                  log_data,
  output logic [$clog2(LOG_DEPTH):0]   log_count,
  output logic                         log_overflow,
  output logic                         misaligned,
  output logic                         done,
  output logic                         pass
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int LW = $clog2(LOG_DEPTH);
  localparam int CW = LW + 1;
  localparam logic [CW-1:0] LOG_FULL    = CW'(LOG_DEPTH);
  localparam logic [32:0]   ARRAY_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  // Storage arrays: the data array is deliberately never reset so that
  // program data survives a mid-test reset.
  logic [31:0] mem_q      [DEPTH_WORDS];
  logic [31:0] log_addr_q [LOG_DEPTH];
  logic [31:0] log_data_q [LOG_DEPTH];

  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          mis_q, mis_d;
  logic          ovf_q, ovf_d;

  logic          is_tohost, is_aligned, in_range, is_array;
  logic [AW-1:0] word_idx;
  logic          store_live, accept, array_we;
  logic          log_full, log_empty, pop, push;

  // Address classification; TOHOST takes priority over the array window.
  always_comb begin
    is_tohost  = (dataaddr == TOHOST_ADDR);
    is_aligned = (dataaddr[1:0] == 2'b00);
    in_range   = ({1'b0, dataaddr} < ARRAY_BYTES);
    is_array   = is_aligned && !is_tohost && in_range;
    word_idx   = dataaddr[AW+1:2];
  end

  // A store is only live outside reset and before the test has finished;
  // once done is set the responder freezes all store side effects.
  always_comb begin
    store_live = memwrite && reset && !done_q;
    accept     = store_live && (is_tohost || is_array);
    array_we   = store_live && is_array;
    log_full   = (count_q == LOG_FULL);
    log_empty  = (count_q == '0);
    pop        = log_pop && reset && !log_empty;
    // When full, a same-cycle pop frees the slot so the push still lands.
    push       = accept && (!log_full || pop);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    done_d   = done_q;
    pass_d   = pass_q;
    mis_d    = mis_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + LW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + LW'(1);

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    if (accept && !push) ovf_d = 1'b1;
    if (store_live && !is_aligned) mis_d = 1'b1;

    if (accept && is_tohost) begin
      done_d = 1'b1;
      pass_d = (writedata == 32'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      mis_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      mis_q    <= mis_d;
      ovf_q    <= ovf_d;
    end
  end

  // Array and log storage writes; enables are already gated by reset.
  always_ff @(posedge clk) begin
    if (array_we) mem_q[word_idx] <= writedata;
    if (push) begin
      log_addr_q[wr_ptr_q] <= dataaddr;
      log_data_q[wr_ptr_q] <= writedata;
    end
  end

  always_comb begin
    readdata     = (reset && is_array) ? mem_q[word_idx] : '0;
    log_valid    = reset && !log_empty;
    log_addr     = log_addr_q[rd_ptr_q];
    log_data     = log_data_q[rd_ptr_q];
    log_count    = count_q;
    log_overflow = ovf_q;
    misaligned   = mis_q;
    done         = done_q;
    pass         = pass_q;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the multicycle MIPS CPU's data port (`memwrite`, `dataaddr`, `writedata`). It serves word loads and stores and decodes a memory-mapped `tohost` word that ends a benchtest with done and pass flags. It also records every accepted store in a small first-word-fall-through log for inspection by benches. It is the target-side counterpart of the CPU's store interface and replaces ad-hoc end-of-time checks on `writedata`/`dataaddr`.

## Interface

**Parameters**
- `DEPTH_WORDS`, default 64: data array size in 32-bit words; power of two.
- `LOG_DEPTH`, default 8: store-log entries; power of two, at least 2.
- `TOHOST_ADDR`, default 32'hFFFF_FFF0: byte address of the test-result word.

**Ports**
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-low. 0 means in reset.
- `memwrite` in 1: store strobe; each cycle it is high counts as one store.
- `dataaddr` in 32: byte address for both loads and stores.
- `writedata` in 32: store data.
- `readdata` out 32: combinational load data.
- `log_pop` in 1: consume the log head.
- `log_valid` out 1: log is non-empty.
- `log_addr` out 32: head entry address.
- `log_data` out 32: head entry data.
- `log_count` out $clog2(LOG_DEPTH)+1: number of entries held.
- `log_overflow` out 1: sticky; set when a push is dropped because the log is full.
- `misaligned` out 1: sticky; set when a store has `dataaddr[1:0]` != 0.
- `done` out 1: sticky; set when `tohost` has been written.
- `pass` out 1: result captured with `done`.

## Operation

**Address classes** (evaluated every cycle):
- TOHOST: `dataaddr` == TOHOST_ADDR.
- ARRAY: aligned, not TOHOST, and `dataaddr` < DEPTH_WORDS*4. Word index is `dataaddr[$clog2(DEPTH_WORDS)+1:2]`.
- OTHER: every remaining address.

**Loads**
- `readdata` = array word for ARRAY addresses.
- `readdata` = 0 for TOHOST, OTHER, misaligned addresses, and whenever `reset`=0.

**Store acceptance**
- A store is accepted when `memwrite`=1, `reset`=1, `done`=0, and the class is ARRAY or TOHOST.
- Misaligned store: dropped and not logged; sets `misaligned`.
- OTHER aligned store: dropped silently and not logged.
- Once `done`=1, every store is ignored: no array write, no log push, no flag change.

**ARRAY store**
- Writes the array word at the clock edge.

**TOHOST store**
- Does not write the array.
- Sets `done`<=1 and `pass`<=(`writedata`==32'd1).

**Store log**
- Every accepted store pushes {`dataaddr`, `writedata`}.
- FWFT: `log_valid` = (`log_count` != 0), and the head entry is always presented on `log_addr`/`log_data`.
- Pop takes effect when `log_pop` && `log_valid`. Pop while empty is ignored.
- Push while full without a pop: entry dropped, `log_overflow`<=1, contents unchanged.
- Push and pop in the same cycle when full: the pop is applied, then the push. Count stays at LOG_DEPTH and no overflow is flagged.
- Push and pop in the same cycle when non-full and non-empty: count unchanged.
- Read and write pointers wrap modulo LOG_DEPTH.

**Reset** (`reset`=0 at an edge):
- `done`, `pass`, `misaligned`, `log_overflow` all go to 0.
- `log_count` goes to 0 and both log pointers go to 0.
- The data array is NOT cleared and keeps its contents across reset, including a reset mid-test.
- While `reset`=0: `log_valid`=0 and `readdata`=0. `log_addr`/`log_data` are don't-care.

## Timing

- Load latency: 0 cycles; `readdata` is combinational from `dataaddr`.
- An ARRAY store at edge N is visible on `readdata` after edge N, i.e. in cycle N+1 for the same address.
- Log push at edge N: `log_valid`/`log_count` update in cycle N+1.
- Pop at edge N: the next head appears in cycle N+1.
- A TOHOST store at edge N: `done`/`pass` are high in cycle N+1.
- Sticky flags set at edge N are visible from cycle N+1 until the next reset.
- A store held high for k cycles counts as k stores. The CPU pulses `memwrite` for one cycle per `sw`.

## Test plan

1. **Reset values.** Hold `reset`=0 for 2 cycles with `dataaddr`=0 → `done`=0, `pass`=0, `log_valid`=0, `log_count`=0, `misaligned`=0, `log_overflow`=0, `readdata`=0.
2. **Store, load, log, pop.** Store 32'd6 to 0x18, then drive `dataaddr`=0x18 → next cycle `readdata`=6, `log_valid`=1, `log_addr`=0x18, `log_data`=6, `log_count`=1. Pulse `log_pop` → `log_valid`=0, `log_count`=0.
3. **Misaligned store.** Store 32'd6 to 0x6 after 0x4 holds 32'hA5 → `misaligned`=1, read of 0x4 still returns 32'hA5, `log_count` unchanged.
4. **Log overflow and wrap.** 8 stores to 0x0..0x1C with no pop → `log_count`=8, head = {0x0, data0}. A 9th store → `log_overflow`=1, count stays 8. Store plus pop in the same cycle → count stays 8 and the new tail is the last entry read out after 7 further pops.
5. **tohost result.** Store 32'd1 to TOHOST_ADDR → next cycle `done`=1, `pass`=1. A following store of 32'd9 to 0x20 leaves `readdata`@0x20 unchanged and `log_count` unchanged. In a separate run, storing 32'd3 → `done`=1, `pass`=0.
6. **Reset mid-operation.** With 3 log entries, `done`=1, and 0x18=6, assert `reset`=0 for 1 cycle → all flags 0 and `log_count`=0. After release, a read of 0x18 returns 6.
